serial_to_parallel: RTL and testbench

- Gathers a stream of single WIDTH-bit elements, one per valid/ready handshake, into a BUFFER_SIZE-entry register bank.
- Presents the complete bank as one parallel vector with a valid/ready handshake.
- It is the inverse of the team's parallel-load rotating shift register. It sits upstream of blocks that consume whole vectors, such as reductions and parallel matmul lanes.

---
 rtl/serial_to_parallel_pkg.sv | 11 +
 rtl/serial_to_parallel.sv | 97 +++++++++
 tb/tb_serial_to_parallel.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_pkg.sv
// Shared types and helpers for the serial_to_parallel gatherer.
`timescale 1ns/1ps
package serial_to_parallel_pkg;

  typedef enum logic {FILL, FULL} s2p_state_t;

  function automatic int s2p_idx_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Gathers BUFFER_SIZE serial elements into one parallel vector with valid/ready on both sides.
// Optional early frame close and element count: define SERIAL_TO_PARALLEL_FLUSH_EN.
`timescale 1ns/1ps
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int BUFFER_SIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
  input  logic             data_in_last,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] data_out_count,
`endif
  output logic [WIDTH-1:0] data_out [BUFFER_SIZE-1:0],
  output logic             data_out_valid,
  input  logic             data_out_ready
);

  localparam int              IDX_W    = s2p_idx_width(BUFFER_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_SIZE - 1);

  s2p_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, wr_idx;
  logic [WIDTH-1:0] bank [BUFFER_SIZE-1:0];
  logic             in_fire, out_fire, in_last, wr_en, close;

  assign data_in_ready  = (state == FILL) || data_out_ready;
  assign data_out_valid = (state == FULL);
  assign in_fire        = data_in_valid && data_in_ready;
  assign out_fire       = data_out_valid && data_out_ready;
  assign data_out       = bank;

`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
  assign in_last = data_in_last;
`else
  assign in_last = 1'b0;
`endif

  // An accept while FULL can only coincide with a drain, so it starts the next frame at slot 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    close     = 1'b0;
    wr_idx    = (state == FULL) ? '0 : idx;
    if (in_fire) begin
      wr_en = 1'b1;
      close = (wr_idx == LAST_IDX) || in_last;
      if (close) begin
        idx_nxt   = '0;
        state_nxt = FULL;
      end else begin
        idx_nxt   = wr_idx + IDX_W'(1);
        state_nxt = FILL;
      end
    end else if (out_fire) begin
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // A short frame clears the slots above the last written one on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) bank[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        if (i == int'(wr_idx)) bank[i] <= data_in;
        else if (in_last && (i > int'(wr_idx))) bank[i] <= '0;
      end
    end
  end

`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_out_count <= '0;
    else if (wr_en && close) data_out_count <= CNT_W'(wr_idx) + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed cases on a 4x8 instance, random streaming on 4x8 and 1x16.
`timescale 1ns/1ps
module tb_serial_to_parallel;

  localparam int AW = 8;
  localparam int AB = 4;
  localparam int BW = 16;
  localparam int BB = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] a_din;
  logic          a_vld, a_irdy, a_ovld, a_ordy;
  logic [AW-1:0] a_dout [AB-1:0];
  logic [BW-1:0] b_din;
  logic          b_vld, b_irdy, b_ovld, b_ordy;
  logic [BW-1:0] b_dout [BB-1:0];
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
  logic          a_last, b_last;
  logic [2:0]    a_cnt;
  logic [0:0]    b_cnt;
`endif

  serial_to_parallel #(.WIDTH(AW), .BUFFER_SIZE(AB)) dut_a (
    .clk(clk), .rst(rst),
    .data_in(a_din), .data_in_valid(a_vld), .data_in_ready(a_irdy),
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
    .data_in_last(a_last), .data_out_count(a_cnt),
`endif
    .data_out(a_dout), .data_out_valid(a_ovld), .data_out_ready(a_ordy)
  );

  serial_to_parallel #(.WIDTH(BW), .BUFFER_SIZE(BB)) dut_b (
    .clk(clk), .rst(rst),
    .data_in(b_din), .data_in_valid(b_vld), .data_in_ready(b_irdy),
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
    .data_in_last(b_last), .data_out_count(b_cnt),
`endif
    .data_out(b_dout), .data_out_valid(b_ovld), .data_out_ready(b_ordy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {a_dout[3], a_dout[2], a_dout[1], a_dout[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [AW-1:0] d);
    a_din = d;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
  endtask

  // Reference model: queues of accepted elements; each drained vector must equal the next frame of them.
  logic          mon_en = 1'b0;
  logic          a_fired = 1'b0, b_fired = 1'b0;
  logic          a_wait = 1'b0, b_wait = 1'b0;
  logic [AW-1:0] a_wait_d = '0;
  logic [BW-1:0] b_wait_d = '0;
  logic [AW-1:0] a_q[$];
  logic [BW-1:0] b_q[$];
  int a_acc = 0, b_acc = 0, a_frames = 0, b_frames = 0;

  always @(negedge clk) begin
    a_fired = a_vld && a_irdy;
    b_fired = b_vld && b_irdy;
    if (mon_en && rst) begin
      if (a_wait) begin
        check("a_vld_hold", a_vld, 1);
        check("a_din_hold", a_din, a_wait_d);
      end
      if (b_wait) begin
        check("b_vld_hold", b_vld, 1);
        check("b_din_hold", b_din, b_wait_d);
      end
      if (a_ovld && a_ordy) begin
        if (a_q.size() < AB) check("a_underflow", a_q.size(), AB);
        else for (int i = 0; i < AB; i++) begin
          logic [AW-1:0] e;
          e = a_q.pop_front();
          check("a_elem", a_dout[i], e);
        end
        a_frames++;
      end
      if (b_ovld && b_ordy) begin
        if (b_q.size() < BB) check("b_underflow", b_q.size(), BB);
        else for (int i = 0; i < BB; i++) begin
          logic [BW-1:0] e;
          e = b_q.pop_front();
          check("b_elem", b_dout[i], e);
        end
        b_frames++;
      end
      if (a_fired) begin a_q.push_back(a_din); a_acc++; end
      if (b_fired) begin b_q.push_back(b_din); b_acc++; end
      a_wait   = a_vld && !a_irdy;
      a_wait_d = a_din;
      b_wait   = b_vld && !b_irdy;
      b_wait_d = b_din;
    end
  end

  initial begin
    int cyc;
    a_din = '0; a_vld = 1'b0; a_ordy = 1'b0;
    b_din = '0; b_vld = 1'b0; b_ordy = 1'b0;
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
    a_last = 1'b0; b_last = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_vld", a_ovld, 0);
    check("rst_a_irdy", a_irdy, 1);
    check("rst_a_vec", pack_a(), 0);
    check("rst_b_vld", b_ovld, 0);
    check("rst_b_irdy", b_irdy, 1);
    check("rst_b_vec", b_dout[0], 0);
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
    check("rst_a_cnt", a_cnt, 0);
`endif
    #3 rst = 1'b1;
    tick();

    a_ordy = 1'b1;
    send_a(8'h11); send_a(8'h22); send_a(8'h33);
    check("basic_vld_early", a_ovld, 0);
    send_a(8'h44);
    check("basic_vld", a_ovld, 1);
    check("basic_vec", pack_a(), 32'h44332211);
`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
    check("basic_cnt", a_cnt, 4);
`endif
    tick();
    check("basic_drain", a_ovld, 0);

    a_ordy = 1'b0;
    send_a(8'h55); send_a(8'h66); send_a(8'h77); send_a(8'h88);
    for (int c = 0; c < 5; c++) begin
      check("bp_irdy", a_irdy, 0);
      check("bp_vld", a_ovld, 1);
      check("bp_vec", pack_a(), 32'h88776655);
      tick();
    end
    a_ordy = 1'b1;
    a_din  = 8'hA0;
    a_vld  = 1'b1;
    #1;
    check("bp_release_irdy", a_irdy, 1);
    tick();
    a_vld = 1'b0;
    check("nobubble_vld", a_ovld, 0);
    check("nobubble_b0", a_dout[0], 8'hA0);
    send_a(8'hA1); send_a(8'hA2);
    check("nobubble_vld_early", a_ovld, 0);
    send_a(8'hA3);
    check("nobubble_vld_full", a_ovld, 1);
    check("nobubble_vec", pack_a(), 32'hA3A2A1A0);
    tick();

    send_a(8'hE1); tick(); send_a(8'hE2);
    a_ordy = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_vld", a_ovld, 0);
    check("midrst_irdy", a_irdy, 1);
    check("midrst_vec", pack_a(), 0);
    #3 rst = 1'b1;
    tick();
    send_a(8'h01); tick(); send_a(8'h02); send_a(8'h03); tick(); tick();
    check("gap_vld_early", a_ovld, 0);
    send_a(8'h04);
    check("gap_vld", a_ovld, 1);
    check("gap_vec", pack_a(), 32'h04030201);
    a_ordy = 1'b1;
    tick();
    check("gap_drain", a_ovld, 0);

`ifdef SERIAL_TO_PARALLEL_FLUSH_EN
    send_a(8'h05);
    a_last = 1'b1;
    send_a(8'h06);
    a_last = 1'b0;
    check("flush_vld", a_ovld, 1);
    check("flush_vec", pack_a(), 32'h00000605);
    check("flush_cnt", a_cnt, 2);
    tick();
`endif

    #2 rst = 1'b0;
    #3 rst = 1'b1;
    tick();
    mon_en = 1'b1;
    cyc = 0;
    while ((a_frames < 100 || b_frames < 100) && cyc < 20000) begin
      if (!(a_vld && !a_fired)) begin
        if (a_acc < 100 * AB && $urandom_range(0, 3) != 0) begin
          a_vld = 1'b1;
          a_din = AW'($urandom);
        end else a_vld = 1'b0;
      end
      if (!(b_vld && !b_fired)) begin
        if (b_acc < 100 * BB && $urandom_range(0, 2) != 0) begin
          b_vld = 1'b1;
          b_din = BW'($urandom);
        end else b_vld = 1'b0;
      end
      a_ordy = 1'($urandom_range(0, 1));
      b_ordy = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    a_vld = 1'b0;
    b_vld = 1'b0;
    check("stream_a_frames", a_frames, 100);
    check("stream_b_frames", b_frames, 100);
    check("stream_a_leftover", a_q.size(), 0);
    check("stream_b_leftover", b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
